// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port,
// optional r0 hardwiring, write-to-read bypass and a busy scoreboard.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyEff;
    logic [DEPTH-1:0]  busyNext;
    logic              wrEff;
    logic              rsvZero;
    logic              bypass1;
    logic              bypass2;

    assign wrEff   = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
    assign rsvZero = (ZERO_REG != 0) && (rsv_addr == '0);
    assign bypass1 = (BYPASS != 0) && wrEff && (wr_addr == rd_addr1);
    assign bypass2 = (BYPASS != 0) && wrEff && (wr_addr == rd_addr2);

    // Writeback frees its register before the reservation is judged,
    // so a producer may claim a register retiring this very cycle.
    always_comb begin
        busyEff = busy;
        if (wrEff) begin
            busyEff[wr_addr] = 1'b0;
        end
        rsv_ok   = rsv_en && !rst && (rsvZero || !busyEff[rsv_addr]);
        busyNext = busyEff;
        if (rsv_ok && !rsvZero) begin
            busyNext[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_busy1 = busy[rd_addr1];
        if (bypass1) begin
            rd_data1 = wr_data;
            rd_busy1 = 1'b0;
        end
        if (ZERO_REG != 0 && rd_addr1 == '0) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end
        rd_data2 = regs[rd_addr2];
        rd_busy2 = busy[rd_addr2];
        if (bypass2) begin
            rd_data2 = wr_data;
            rd_busy2 = 1'b0;
        end
        if (ZERO_REG != 0 && rd_addr2 == '0) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wrEff) begin
                regs[wr_addr] <= wr_data;
            end
            busy <= busyNext;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default, no-bypass and
// a 16x16 no-zero-register instance driven side by side.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rdAddr1, rdAddr2, wrAddr, rsvAddr;
    logic [31:0] wrData;
    logic        wrEn, rsvEn;

    logic [31:0] rdData1, rdData2, nbData1, nbData2;
    logic        rdBusy1, rdBusy2, nbBusy1, nbBusy2;
    logic        rsvOk, nbRsvOk;

    logic [3:0]  wRd1, wRd2, wWrAddr, wRsvAddr;
    logic [15:0] wWrData, wData1, wData2;
    logic        wWrEn, wRsvEn, wBusy1, wBusy2, wRsvOk;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rdAddr1), .rd_addr2(rdAddr2),
        .rd_data1(rdData1), .rd_data2(rdData2),
        .rd_busy1(rdBusy1), .rd_busy2(rdBusy2),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr), .rsv_ok(rsvOk)
    );

    regfile_scoreboard #(.BYPASS(0)) dutNb (
        .clk(clk), .rst(rst),
        .rd_addr1(rdAddr1), .rd_addr2(rdAddr2),
        .rd_data1(nbData1), .rd_data2(nbData2),
        .rd_busy1(nbBusy1), .rd_busy2(nbBusy2),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr), .rsv_ok(nbRsvOk)
    );

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dutWide (
        .clk(clk), .rst(rst),
        .rd_addr1(wRd1), .rd_addr2(wRd2),
        .rd_data1(wData1), .rd_data2(wData2),
        .rd_busy1(wBusy1), .rd_busy2(wBusy2),
        .wr_en(wWrEn), .wr_addr(wWrAddr), .wr_data(wWrData),
        .rsv_en(wRsvEn), .rsv_addr(wRsvAddr), .rsv_ok(wRsvOk)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wrEn  = 1'b0;
        rsvEn = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {rdAddr1, rdAddr2, wrAddr, rsvAddr} = '0;
        wrData = '0;
        idle();
        {wRd1, wRd2, wWrAddr, wRsvAddr} = '0;
        wWrData = '0;
        wWrEn = 1'b0;
        wRsvEn = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        rdAddr1 = 3'd5;
        #1;
        check("rst_data", rdData1, 32'h0);
        check("rst_busy", {31'b0, rdBusy1}, 32'h0);

        // write r5, reserve r5, then reset with a write in flight
        wrEn = 1'b1; wrAddr = 3'd5; wrData = 32'hDEADBEEF;
        tick();
        idle();
        rsvEn = 1'b1; rsvAddr = 3'd5;
        #1;
        check("r5_wr", rdData1, 32'hDEADBEEF);
        check("r5_rsv_ok", {31'b0, rsvOk}, 32'h1);
        tick();
        idle();
        #1;
        check("r5_busy", {31'b0, rdBusy1}, 32'h1);
        rst = 1'b1;
        wrEn = 1'b1; wrAddr = 3'd5; wrData = 32'h11111111;
        rsvEn = 1'b1; rsvAddr = 3'd6;
        #1;
        check("rst_rsv_ok", {31'b0, rsvOk}, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        rdAddr2 = 3'd6;
        #1;
        check("rst_r5_data", rdData1, 32'h0);
        check("rst_r5_busy", {31'b0, rdBusy1}, 32'h0);
        check("rst_r6_busy", {31'b0, rdBusy2}, 32'h0);

        // bypass: r3 busy with old value, then written back
        wrEn = 1'b1; wrAddr = 3'd3; wrData = 32'h0BAD0003;
        rsvEn = 1'b1; rsvAddr = 3'd3;
        tick();
        idle();
        wrEn = 1'b1; wrAddr = 3'd3; wrData = 32'h12345678;
        rdAddr1 = 3'd3; rdAddr2 = 3'd3;
        #1;
        check("byp_d1", rdData1, 32'h12345678);
        check("byp_d2", rdData2, 32'h12345678);
        check("byp_b1", {31'b0, rdBusy1}, 32'h0);
        check("nb_d1", nbData1, 32'h0BAD0003);
        check("nb_d2", nbData2, 32'h0BAD0003);
        check("nb_b1", {31'b0, nbBusy1}, 32'h1);
        tick();
        idle();
        #1;
        check("nb_after", nbData2, 32'h12345678);
        check("nb_busy_after", {31'b0, nbBusy2}, 32'h0);

        // zero register
        wrEn = 1'b1; wrAddr = 3'd0; wrData = 32'hFFFFFFFF;
        rsvEn = 1'b1; rsvAddr = 3'd0;
        rdAddr1 = 3'd0; rdAddr2 = 3'd0;
        #1;
        check("r0_d1", rdData1, 32'h0);
        check("r0_rsv_ok", {31'b0, rsvOk}, 32'h1);
        check("r0_b1", {31'b0, rdBusy1}, 32'h0);
        tick();
        wrEn = 1'b0;
        #1;
        check("r0_d2_post", rdData2, 32'h0);
        check("r0_b2_post", {31'b0, rdBusy2}, 32'h0);
        check("r0_rsv_again", {31'b0, rsvOk}, 32'h1);
        tick();
        idle();

        // scoreboard RAW/WAW on r4
        rsvEn = 1'b1; rsvAddr = 3'd4; rdAddr1 = 3'd4;
        #1;
        check("r4_rsv_ok", {31'b0, rsvOk}, 32'h1);
        tick();
        #1;
        check("r4_busy", {31'b0, rdBusy1}, 32'h1);
        check("r4_waw", {31'b0, rsvOk}, 32'h0);
        tick();
        #1;
        check("r4_hold", {31'b0, rdBusy1}, 32'h1);
        rsvEn = 1'b0;
        wrEn = 1'b1; wrAddr = 3'd4; wrData = 32'h55;
        #1;
        check("r4_wb_d", rdData1, 32'h55);
        check("r4_wb_b", {31'b0, rdBusy1}, 32'h0);
        tick();
        idle();
        rsvEn = 1'b1; rsvAddr = 3'd4;
        #1;
        check("r4_post_d", rdData1, 32'h55);
        check("r4_post_b", {31'b0, rdBusy1}, 32'h0);
        check("r4_rsv2", {31'b0, rsvOk}, 32'h1);
        tick();
        idle();

        // simultaneous write and reservation of busy r2
        rsvEn = 1'b1; rsvAddr = 3'd2;
        tick();
        wrEn = 1'b1; wrAddr = 3'd2; wrData = 32'hAA;
        #1;
        check("r2_sim_ok", {31'b0, rsvOk}, 32'h1);
        tick();
        idle();
        rdAddr1 = 3'd2;
        rsvEn = 1'b1;
        #1;
        check("r2_data", rdData1, 32'hAA);
        check("r2_busy", {31'b0, rdBusy1}, 32'h1);
        check("r2_waw", {31'b0, rsvOk}, 32'h0);
        idle();

        // write to a non-busy register
        wrEn = 1'b1; wrAddr = 3'd7; wrData = 32'h77;
        tick();
        idle();
        rdAddr2 = 3'd7;
        #1;
        check("r7_data", rdData2, 32'h77);
        check("r7_busy", {31'b0, rdBusy2}, 32'h0);

        // 16x16 instance: every register independent, r0 writable
        for (int i = 0; i < 16; i++) begin
            wWrEn = 1'b1;
            wWrAddr = 4'(i);
            wWrData = (i == 15) ? 16'hBEEF : 16'h1100 + 16'(i);
            tick();
        end
        wWrEn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wRd1 = 4'(i);
            wRd2 = 4'(15 - i);
            #1;
            check($sformatf("w_r%0d", i), {16'b0, wData1},
                  (i == 15) ? 32'hBEEF : 32'h1100 + 32'(i));
            check($sformatf("w2_r%0d", 15 - i), {16'b0, wData2},
                  (i == 0) ? 32'hBEEF : 32'h1100 + 32'(15 - i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the processor's 8x32 register block, used by the next-generation datapath.
- Provides two combinational read ports and one clocked write port, with optional register-0 hardwiring and write-to-read bypass.
- Adds a per-register busy scoreboard so the issue stage can reserve a destination register and stall on RAW/WAW hazards until writeback.
- Sits between decode/issue and writeback.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1: register 0 reads 0, ignores writes, and is never busy.
- BYPASS, 1, when 1: a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data (combinational).
- rd_data2  out  DATA_W  read port 2 data (combinational).
- rd_busy1  out  1  register at rd_addr1 still awaits writeback.
- rd_busy2  out  1  register at rd_addr2 still awaits writeback.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data.
- rsv_en  in  1  issue stage requests reservation of rsv_addr.
- rsv_addr  in  ADDR_W  register to reserve.
- rsv_ok  out  1  reservation accepted this cycle (combinational).

Behaviour:
- Reset: clk is the single clock; rst is synchronous, active-high. At a rising edge with rst=1, all registers clear to 0 and all busy bits clear. Writes and reservations in that cycle are discarded. rsv_ok is forced to 0 while rst=1. Reset mid-reservation drops the reservation; no pending state survives.
- Effective write: wr_en=1 and not (ZERO_REG=1 and wr_addr=0). On the rising edge, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0, unless the same edge sets it (see reservations).
- Reads: rd_dataN = reg[rd_addrN] combinationally; read latency is 0 cycles.
  - ZERO_REG=1 and rd_addrN=0: rd_dataN = 0.
  - BYPASS=1 and an effective write with wr_addr=rd_addrN: rd_dataN = wr_data.
  - BYPASS=0: the old value is read until the next edge.
- Busy reporting: rd_busyN = busy[rd_addrN].
  - BYPASS=1 and an effective write to rd_addrN: rd_busyN = 0, because the data is now valid on the bus.
  - ZERO_REG=1 and rd_addrN=0: rd_busyN = 0.
- Reservations: rsv_ok = rsv_en and not rst and not busy_eff[rsv_addr].
  - busy_eff is busy with same-cycle effective-write clearing applied, so a reservation of a register being written back this cycle is accepted.
  - WAW on a still-busy register gives rsv_ok = 0 and no state change. The requester holds rsv_en and retries.
  - When rsv_ok=1, busy[rsv_addr] <= 1 at the edge.
  - ZERO_REG=1 and rsv_addr=0: rsv_ok = rsv_en and no busy bit is set.
- Simultaneous write and accepted reservation to the same address: data is written and busy ends at 1. The reservation wins because it belongs to the newer producer.
- Write to a non-busy register is legal: data updates and busy stays 0.
- Both read ports may address the same register or the write address; both see identical data and busy values.
- No X propagation: every output is defined from reset onward for all address values.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse rst for 1 cycle -> rd_data1(r5)=0, rd_busy1=0; a wr_en in the reset cycle is ignored.
- Bypass: wr_en=1, wr_addr=3, wr_data=0x12345678, rd_addr1=rd_addr2=3 in the same cycle -> both rd_data=0x12345678 before the edge; with BYPASS=0 both show the old value.
- Zero register: write 0xFFFFFFFF to r0 and reserve r0 -> rd_data=0, rd_busy=0, rsv_ok=1, busy never set.
- Scoreboard: reserve r4 -> rsv_ok=1; next cycle rd_busy1(r4)=1 and a second reserve of r4 gives rsv_ok=0; write r4=0x55 -> busy clears, and a following reserve is accepted.
- Simultaneous events: r2 busy, same cycle wr r2=0xAA and rsv r2 -> rsv_ok=1, reg=0xAA, busy=1 after the edge.
- Parameter sweep: DATA_W=16, ADDR_W=4 -> all 16 registers are independently writable and readable; r15 writes and reads back 0xBEEF.
